vr_sink_checker: RTL and testbench
==================================

Name: vr_sink_checker

Overview:
- Parametrised valid/ready sink used as a testbench-side consumer for FIFO and stream blocks.
- Generates programmable backpressure in four modes: fixed delay, pseudo-random delay, always-ready and stall.
- Checks received data against an incrementing sequence, and keeps saturating transfer and error counters plus the last received word for the bench to inspect.

Parameters:
- DATA_WIDTH, 8, width of s_data and last_data.
- DELAY_BITS, 3, width of the delay input and the internal delay counter.
- CNT_WIDTH, 16, width of rx_count and err_count.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be nonzero.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mode  input  2  backpressure mode: 0 fixed, 1 random, 2 always-ready, 3 stall.
- delay  input  DELAY_BITS  ready-low cycles between transfers in mode 0.
- check_en  input  1  enables sequence checking.
- clear  input  1  synchronous clear of counters, expected value and error.
- s_valid  input  1  upstream data valid.
- s_data  input  DATA_WIDTH  upstream data.
- s_ready  output  1  registered ready.
- rx_count  output  CNT_WIDTH  number of accepted transfers, saturating.
- err_count  output  CNT_WIDTH  number of sequence mismatches, saturating.
- error  output  1  sticky mismatch flag.
- last_data  output  DATA_WIDTH  last accepted word.

Behaviour:
- Reset values (reset is asynchronous, active-low; clock is clk):
  - s_ready=0, rx_count=0, err_count=0, error=0, last_data=0.
  - expected=0, LFSR=LFSR_SEED, FSM state=IDLE.
- Handshake: a transfer occurs at a rising edge where s_valid=1 and s_ready=1.
- s_ready is a flop output. It is 1 exactly while the FSM is in READY.
- FSM states: IDLE, DELAY, READY, STALL.
- IDLE:
  - Lasts exactly one cycle after reset release.
  - Then performs a delay load (defined below).
- Delay load:
  - Count = delay in mode 0, or LFSR[DELAY_BITS-1:0] in mode 1.
  - If count=0, go to READY; otherwise go to DELAY with the counter set to count.
- DELAY: decrement the counter each cycle; go to READY on the cycle the counter reaches 0. Ready is therefore low for exactly count cycles.
- READY:
  - Hold until a handshake occurs.
  - On handshake in mode 0 or 1, perform a delay load.
  - On handshake in mode 2, stay in READY.
- Mode 0 with delay=0 gives back-to-back acceptance, one transfer per cycle.
- Mode 2 (always-ready): from IDLE or DELAY, go to READY next cycle.
- Mode 3 (stall):
  - From any non-IDLE state, go to STALL next cycle, with s_ready=0.
  - Leaving STALL (mode changes to 0, 1 or 2) performs a delay load, or goes to READY in mode 2.
- Mode changes while in READY (other than to 3) take effect at the next handshake.
- delay and mode are sampled only at decision points; changing delay during DELAY has no effect on the current count.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle regardless of state.
- Accepting a transfer:
  - last_data <= s_data.
  - rx_count <= rx_count+1, saturating at all-ones.
- Checker (applies when check_en=1 on a handshake):
  - If s_data != expected: err_count increments (saturating) and error is set.
  - In all cases expected <= s_data+1, truncated to DATA_WIDTH and wrapping from all-ones to 0. A mismatch therefore resynchronises the checker, so a single dropped word gives exactly one error.
- check_en=0: expected still tracks s_data+1, but no errors are recorded.
- clear:
  - Sets rx_count=0, err_count=0, error=0 and expected=0.
  - clear has priority over a simultaneous handshake: the transfer is accepted (last_data updates) but is neither counted nor checked.
  - clear does not affect the FSM or the LFSR.
- Reset asserted mid-transfer: all state returns immediately to reset values; s_ready drops asynchronously.

Test Plan:
- Mode 0, delay=3, s_valid held 1, data 0,1,2… → first s_ready 1 cycle after IDLE plus 3 cycles; then s_ready high 1 cycle in every 4; after 10 transfers rx_count=10, err_count=0, last_data=9.
- Mode 0, delay=0, continuous valid → s_ready stays 1; 256 transfers at DATA_WIDTH=8 wrap from 255 to 0 with no error; rx_count=256.
- Sequence 0,1,2,4,5 with check_en=1 → err_count=1, error=1, no further errors after the 4 (resync).
- Mode 3 asserted while in READY → s_ready=0 next cycle and no transfers; switch to mode 2 → s_ready=1 the following cycle.
- clear asserted on the same edge as a handshake of data 7 → rx_count=0, error=0, last_data=7; next data 0 gives no error.
- Mode 1, LFSR_SEED=16'hACE1 → ready-low gaps equal the LFSR low 3 bits (golden model); reset mid-DELAY → s_ready=0, counters=0, gaps restart from the seed sequence.

Source files
------------

// File: rtl/vr_sink_checker.sv
// ---------------------------------------------------------------------------
// vr_sink_checker
//
// Testbench-side valid/ready consumer for FIFO and stream blocks. Generates
// programmable backpressure (fixed delay, pseudo-random delay, always-ready,
// stall), checks received words against an incrementing sequence, and keeps
// saturating transfer/error counters plus the last received word.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   mode       in   [1:0] 0 fixed delay, 1 random delay, 2 always-ready, 3 stall
//   delay      in   [DELAY_BITS-1:0] ready-low cycles between transfers (mode 0)
//   check_en   in   enables sequence checking
//   clear      in   synchronous clear of counters, expected value and error
//   s_valid    in   upstream valid
//   s_data     in   [DATA_WIDTH-1:0] upstream data
//   s_ready    out  registered ready (high exactly while in READY)
//   rx_count   out  [CNT_WIDTH-1:0] accepted transfers, saturating
//   err_count  out  [CNT_WIDTH-1:0] sequence mismatches, saturating
//   error      out  sticky mismatch flag
//   last_data  out  [DATA_WIDTH-1:0] last accepted word
// ---------------------------------------------------------------------------
module vr_sink_checker #(
    parameter int          DATA_WIDTH = 8,
    parameter int          DELAY_BITS = 3,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [DELAY_BITS-1:0] delay,
    input  logic                  check_en,
    input  logic                  clear,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [CNT_WIDTH-1:0]  rx_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] last_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_READY = 2'd2,
        ST_STALL = 2'd3
    } state_t;

    localparam logic [1:0] MODE_FIXED  = 2'd0;
    localparam logic [1:0] MODE_RANDOM = 2'd1;
    localparam logic [1:0] MODE_ALWAYS = 2'd2;
    localparam logic [1:0] MODE_STALL  = 2'd3;

    localparam logic [DELAY_BITS-1:0] DLY_ZERO  = {DELAY_BITS{1'b0}};
    localparam logic [DELAY_BITS-1:0] DLY_ONE   = {{(DELAY_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    // Saturating increment so counters stick at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_t                state_r, state_s;
    state_t                load_state_s;
    logic [DELAY_BITS-1:0] cnt_r, cnt_s, load_cnt_s;
    logic [15:0]           lfsr_r;
    logic                  ready_r;
    logic                  handshake_s;
    logic [DATA_WIDTH-1:0] expected_r;
    logic [CNT_WIDTH-1:0]  rx_r, err_r;
    logic                  error_r;
    logic [DATA_WIDTH-1:0] last_r;

    assign handshake_s = s_valid & ready_r;

    assign s_ready   = ready_r;
    assign rx_count  = rx_r;
    assign err_count = err_r;
    assign error     = error_r;
    assign last_data = last_r;

    // Delay load: target state and counter for the current mode.
    always_comb begin
        load_state_s = ST_READY;
        load_cnt_s   = DLY_ZERO;
        case (mode)
            MODE_FIXED: begin
                load_cnt_s   = delay;
                load_state_s = (delay == DLY_ZERO) ? ST_READY : ST_DELAY;
            end
            MODE_RANDOM: begin
                load_cnt_s   = lfsr_r[DELAY_BITS-1:0];
                load_state_s = (lfsr_r[DELAY_BITS-1:0] == DLY_ZERO) ? ST_READY : ST_DELAY;
            end
            MODE_ALWAYS: begin
                load_state_s = ST_READY;
            end
            MODE_STALL: begin
                load_state_s = ST_STALL;
            end
            default: begin
                load_state_s = ST_READY;
            end
        endcase
    end

    // Backpressure FSM next-state logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                state_s = load_state_s;
                cnt_s   = load_cnt_s;
            end
            ST_DELAY: begin
                if (mode == MODE_STALL) begin
                    state_s = ST_STALL;
                end else if (mode == MODE_ALWAYS) begin
                    state_s = ST_READY;
                end else if (cnt_r <= DLY_ONE) begin
                    // Counter reaches zero on this edge: ready rises now.
                    state_s = ST_READY;
                    cnt_s   = DLY_ZERO;
                end else begin
                    cnt_s = cnt_r - DLY_ONE;
                end
            end
            ST_READY: begin
                if (mode == MODE_STALL) begin
                    state_s = ST_STALL;
                end else if (handshake_s && (mode != MODE_ALWAYS)) begin
                    state_s = load_state_s;
                    cnt_s   = load_cnt_s;
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_STALL: begin
                if (mode == MODE_STALL) begin
                    state_s = ST_STALL;
                end else begin
                    state_s = load_state_s;
                    cnt_s   = load_cnt_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = DLY_ZERO;
            end
        endcase
    end

    // FSM state, delay counter, LFSR and registered ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= DLY_ZERO;
            lfsr_r  <= LFSR_SEED;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            lfsr_r  <= lfsr_next(lfsr_r);
            ready_r <= (state_s == ST_READY);
        end
    end

    // Receive datapath: last word, counters and sequence checker.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r     <= DATA_ZERO;
            rx_r       <= CNT_ZERO;
            err_r      <= CNT_ZERO;
            error_r    <= 1'b0;
            expected_r <= DATA_ZERO;
        end else begin
            if (handshake_s) begin
                last_r <= s_data;
            end
            // clear wins over a simultaneous transfer: word captured, not counted.
            if (clear) begin
                rx_r       <= CNT_ZERO;
                err_r      <= CNT_ZERO;
                error_r    <= 1'b0;
                expected_r <= DATA_ZERO;
            end else if (handshake_s) begin
                rx_r <= sat_inc(rx_r);
                if (check_en && (s_data != expected_r)) begin
                    err_r   <= sat_inc(err_r);
                    error_r <= 1'b1;
                end
                // Always resynchronise to the received word.
                expected_r <= s_data + DATA_ONE;
            end
        end
    end

endmodule

// File: tb/tb_vr_sink_checker.sv
// Self-checking bench for vr_sink_checker: directed steps, scoreboard of
// accepted words, independent LFSR golden model for random-mode gaps.
module tb_vr_sink_checker;

    localparam int          DW   = 8;
    localparam int          DB   = 3;
    localparam int          CW   = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    mode;
    logic [DB-1:0] delay;
    logic          check_en;
    logic          clear;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] err_count;
    logic          error;
    logic [DW-1:0] last_data;

    vr_sink_checker #(
        .DATA_WIDTH(DW), .DELAY_BITS(DB), .CNT_WIDTH(CW), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .delay(delay),
        .check_en(check_en), .clear(clear), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .rx_count(rx_count), .err_count(err_count),
        .error(error), .last_data(last_data)
    );

    always #5 clk = ~clk;

    // Golden LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    int            n_checks = 0;
    int            n_errors = 0;
    int            exp_rx;
    int            exp_err;
    logic          exp_error;
    logic [DW-1:0] exp_seq;
    logic [DW-1:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_rx    = 0;
        exp_err   = 0;
        exp_error = 1'b0;
        exp_seq   = 8'd0;
    endtask

    // Offer word d (called #1 after a rising edge); expect exactly exp_gap
    // ready-low cycles before acceptance. Returns LFSR value used at the
    // accepting edge.
    task automatic send(input logic [DW-1:0] d, input int exp_gap, output logic [15:0] lfsr_hs);
        int            waited;
        logic [DW-1:0] popped;
        waited  = 0;
        lfsr_hs = 16'h0000;
        s_valid = 1'b1;
        s_data  = d;
        while (s_ready !== 1'b1 && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        check("gap", waited, exp_gap);
        if (s_ready !== 1'b1) begin
            s_valid = 1'b0;
            return;
        end
        lfsr_hs = m_lfsr;
        sb.push_back(d);
        if (check_en && (d !== exp_seq)) begin
            exp_err++;
            exp_error = 1'b1;
        end
        exp_seq = d + 8'd1;
        exp_rx++;
        @(posedge clk); #1;
        popped = sb.pop_front();
        check("last_data", last_data, popped);
        check("rx_count", rx_count, exp_rx);
        check("err_count", err_count, exp_err);
        check("error", error, exp_error);
    endtask

    initial begin
        logic [15:0]   lh;
        logic [15:0]   seed_v;
        logic [DW-1:0] popped;
        int            gap;
        int            guard;
        seed_v   = SEED;
        mode     = 2'd0;
        delay    = 3'd3;
        check_en = 1'b1;
        clear    = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'd0;
        model_clear();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_rx_count", rx_count, 16'd0);
        check("rst_err_count", err_count, 16'd0);
        check("rst_error", error, 1'b0);
        check("rst_last_data", last_data, 8'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Mode 0, delay 3: IDLE + 3 low cycles first, then one accept per 4
        for (int i = 0; i < 10; i++) send(8'(i), (i == 0) ? 4 : 3, lh);
        check("m0_rx10", rx_count, 16'd10);

        // Delay change during DELAY does not alter the running count
        delay = 3'd0;
        send(8'd10, 3, lh);
        // Back-to-back with wrap 255 -> 0
        for (int i = 0; i < 256; i++) send(8'(11 + i), 0, lh);
        check("wrap_err", err_count, 16'd0);

        // Clear, then dropped word: one error then resync
        s_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
        check("clr_rx", rx_count, 16'd0);
        check("clr_err", err_count, 16'd0);
        send(8'd0, 0, lh);
        send(8'd1, 0, lh);
        send(8'd2, 0, lh);
        send(8'd4, 0, lh);
        send(8'd5, 0, lh);
        send(8'd6, 0, lh);
        check("resync_err", err_count, 16'd1);

        // check_en=0: mismatch ignored, expected still tracks
        check_en = 1'b0;
        send(8'd20, 0, lh);
        check_en = 1'b1;
        send(8'd21, 0, lh);

        // Stall from READY, then always-ready
        s_valid = 1'b0;
        mode = 2'd3;
        @(posedge clk); #1;
        check("stall_ready", s_ready, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'd22;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_hold", s_ready, 1'b0);
            check("stall_rx", rx_count, exp_rx);
        end
        s_valid = 1'b0;
        mode = 2'd2;
        @(posedge clk); #1;
        check("m2_ready", s_ready, 1'b1);
        send(8'd22, 0, lh);
        send(8'd23, 0, lh);

        // clear on the same edge as a handshake of 7
        s_valid = 1'b1;
        s_data  = 8'd7;
        clear   = 1'b1;
        sb.push_back(8'd7);
        @(posedge clk); #1;
        clear   = 1'b0;
        s_valid = 1'b0;
        model_clear();
        popped = sb.pop_front();
        check("clrhs_last", last_data, popped);
        check("clrhs_rx", rx_count, 16'd0);
        check("clrhs_error", error, 1'b0);
        send(8'd0, 0, lh);

        // Mode 1: gaps follow LFSR low bits
        mode = 2'd1;
        send(8'd1, 0, lh);
        for (int i = 0; i < 8; i++) begin
            gap = int'(lh[DB-1:0]);
            send(8'(2 + i), gap, lh);
        end
        // Get into a DELAY of at least 2 cycles, then reset inside it
        guard = 0;
        while (lh[DB-1:0] < 3'd2 && guard < 20) begin
            gap = int'(lh[DB-1:0]);
            send(exp_seq, gap, lh);
            guard++;
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mrst_s_ready", s_ready, 1'b0);
        check("mrst_rx", rx_count, 16'd0);
        check("mrst_err", err_count, 16'd0);
        check("mrst_last", last_data, 8'd0);
        model_clear();
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        send(8'd0, 1 + int'(seed_v[DB-1:0]), lh);
        for (int i = 1; i < 6; i++) begin
            gap = int'(lh[DB-1:0]);
            send(8'(i), gap, lh);
        end

        s_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
